// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding and
// small elaboration-time helpers.
package mul_arb_pkg;

    localparam int MAX_NREQ = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Callers truncate the result to their own requester count.
    function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
        return {{(MAX_NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/IMUL_GENE.sv
// Combinational unsigned SIZE x SIZE array multiplier (shift-and-add of
// partial products); the result is exact, 2*SIZE bits wide.
module IMUL_GENE #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0]   a_i,
    input  logic [SIZE-1:0]   b_i,
    output logic [2*SIZE-1:0] p_o
);

    // Accumulate one shifted copy of A for every set bit of B.
    always_comb begin
        p_o = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (b_i[i]) begin
                p_o = p_o + ({{SIZE{1'b0}}, a_i} << i);
            end else begin
                p_o = p_o;
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner selection: rotate the request vector so the pointer
// position sits at bit 0, priority-encode, then rotate the index back.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]                  req_i,
    input  logic [((NREQ > 1) ? clog2(NREQ) : 1)-1:0] ptr_i,
    output logic [((NREQ > 1) ? clog2(NREQ) : 1)-1:0] win_o,
    output logic                             any_o
);

    localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;

    logic [NREQ-1:0] rot_s;
    logic [PW-1:0]   off_s;
    logic [PW:0]     sum_s;

    assign rot_s = NREQ'({req_i, req_i} >> ptr_i);

    // Lowest set bit of the rotated vector is the closest requester after ptr.
    always_comb begin
        off_s = '0;
        any_o = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = PW'(i);
                any_o = 1'b1;
            end else begin
                off_s = off_s;
            end
        end
    end

    assign sum_s = {1'b0, ptr_i} + {1'b0, off_s};
    assign win_o = (sum_s >= (PW+1)'(NREQ)) ? PW'(sum_s - (PW+1)'(NREQ)) : PW'(sum_s);

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one combinational array multiplier between NREQ requesters with
// round-robin arbitration; the product is held, tagged, until acknowledged.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      iReq,
    input  logic [NREQ*SIZE-1:0] iOpA,
    input  logic [NREQ*SIZE-1:0] iOpB,
    output logic [NREQ-1:0]      oGrant,
    output logic                 oBusy,
    output logic                 oValid,
    output logic [2*SIZE-1:0]    oResult,
    output logic [NREQ-1:0]      oDest,
    input  logic                 iAck
);

    localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int CW = (SETTLE > 1) ? clog2(SETTLE) : 1;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       w_q, w_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SIZE-1:0]     ra_q, ra_d;
    logic [SIZE-1:0]     rb_q, rb_d;
    logic [2*SIZE-1:0]   result_q, result_d;
    logic [NREQ-1:0]     dest_q, dest_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                valid_q, valid_d;

    logic [PW-1:0]       win_s;
    logic                any_s;
    logic [2*SIZE-1:0]   prod_s;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i (iReq),
        .ptr_i (ptr_q),
        .win_o (win_s),
        .any_o (any_s)
    );

    // Fed only from the operand registers: rA/rB -> oResult is a SETTLE-cycle multicycle path.
    IMUL_GENE #(
        .SIZE (SIZE)
    ) u_mul (
        .a_i (ra_q),
        .b_i (rb_q),
        .p_o (prod_s)
    );

    // Next-state and datapath decisions for the IDLE/WAIT/DONE sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        result_d = result_q;
        dest_d   = dest_q;
        valid_d  = valid_q;
        grant_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (win_s == PW'(k)) begin
                            ra_d = iOpA[k*SIZE +: SIZE];
                            rb_d = iOpB[k*SIZE +: SIZE];
                        end else begin
                            ra_d = ra_d;
                            rb_d = rb_d;
                        end
                    end
                    w_d     = win_s;
                    cnt_d   = CW'(SETTLE - 1);
                    grant_d = NREQ'(onehot(32'(win_s)));
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    result_d = prod_s;
                    dest_d   = NREQ'(onehot(32'(w_q)));
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (iAck) begin
                    valid_d = 1'b0;
                    ptr_d   = (w_q == PW'(NREQ - 1)) ? '0 : w_q + PW'(1);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight product.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            w_q      <= '0;
            cnt_q    <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            result_q <= '0;
            dest_q   <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            result_q <= result_d;
            dest_q   <= dest_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
        end
    end

    assign oGrant  = grant_q;
    assign oBusy   = (state_q != ST_IDLE);
    assign oValid  = valid_q;
    assign oResult = result_q;
    assign oDest   = dest_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter (SIZE=16, NREQ=4, SETTLE=2).
module tb_mul_share_arbiter;

    localparam int SIZE   = 16;
    localparam int NREQ   = 4;
    localparam int SETTLE = 2;

    typedef struct packed {
        logic [NREQ-1:0]   dest;
        logic [2*SIZE-1:0] res;
    } exp_t;

    logic                 clk;
    logic                 Reset;
    logic [NREQ-1:0]      iReq;
    logic [NREQ*SIZE-1:0] iOpA;
    logic [NREQ*SIZE-1:0] iOpB;
    logic [NREQ-1:0]      oGrant;
    logic                 oBusy;
    logic                 oValid;
    logic [2*SIZE-1:0]    oResult;
    logic [NREQ-1:0]      oDest;
    logic                 iAck;

    int   checks;
    int   errors;
    int   mdl_ptr;
    exp_t sb[$];

    mul_share_arbiter #(
        .SIZE   (SIZE),
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .Clock   (clk),
        .Reset   (Reset),
        .iReq    (iReq),
        .iOpA    (iOpA),
        .iOpB    (iOpB),
        .oGrant  (oGrant),
        .oBusy   (oBusy),
        .oValid  (oValid),
        .oResult (oResult),
        .oDest   (oDest),
        .iAck    (iAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int mdl_pick(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    // Drive a request and push what the model says the result will be.
    task automatic drive_req(input logic [NREQ-1:0] req, input logic [NREQ*SIZE-1:0] a,
                             input logic [NREQ*SIZE-1:0] b, output int w);
        exp_t e;
        iReq = req;
        iOpA = a;
        iOpB = b;
        w = mdl_pick(req, mdl_ptr);
        e.dest = NREQ'(1 << w);
        e.res  = 32'(16'(a >> (w * SIZE))) * 32'(16'(b >> (w * SIZE)));
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) e = '1;
        else e = sb.pop_front();
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (oGrant != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (oValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (oGrant !== 4'b0000 || oBusy !== 1'b0 || oValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got grant=%b busy=%b valid=%b want 0000/0/0", oGrant, oBusy, oValid);
        end
        checks++;
        if (oResult !== 32'h0 || oDest !== 4'b0000) begin
            errors++;
            $display("FAIL reset_data: got result=%h dest=%b want 0/0000", oResult, oDest);
        end
        Reset = 1'b0;
        mdl_ptr = 0;
        sb.delete();
        tick();
    endtask

    task automatic test_basic();
        int w;
        exp_t e;
        drive_req(4'b0010, {32'h0, 16'h00FF, 16'h0}, {32'h0, 16'h0101, 16'h0}, w);
        tick();
        checks++;
        if (oGrant !== 4'b0010) begin
            errors++;
            $display("FAIL t1_grant: got %b want 0010", oGrant);
        end
        iReq = '0;
        tick();
        checks++;
        if (oValid !== 1'b0 || oGrant !== 4'b0000 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL t1_early: got valid=%b grant=%b busy=%b want 0/0000/1", oValid, oGrant, oBusy);
        end
        tick();
        checks++;
        if (oValid !== 1'b1) begin
            errors++;
            $display("FAIL t1_latency: got valid=%b want 1", oValid);
        end
        pop_exp(e);
        checks++;
        if (oResult !== e.res || oResult !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL t1_result: got %h want %h", oResult, e.res);
        end
        checks++;
        if (oDest !== e.dest) begin
            errors++;
            $display("FAIL t1_dest: got %b want %b", oDest, e.dest);
        end
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        checks++;
        if (oValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL t1_ack: got valid=%b busy=%b want 0/0", oValid, oBusy);
        end
        mdl_ptr = (w + 1) % NREQ;
    endtask

    task automatic test_boundary();
        logic [SIZE-1:0] ta[2];
        logic [SIZE-1:0] tb[2];
        int   w;
        bit   ok;
        exp_t e;
        ta[0] = 16'hFFFF; tb[0] = 16'hFFFF;
        ta[1] = 16'h0000; tb[1] = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            drive_req(4'b0001, {48'h0, ta[i]}, {48'h0, tb[i]}, w);
            tick();
            checks++;
            if (oGrant !== 4'b0001) begin
                errors++;
                $display("FAIL t2_grant[%0d]: got %b want 0001", i, oGrant);
            end
            iReq = '0;
            wait_valid(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL t2_valid_timeout[%0d]: got valid=%b want 1", i, oValid);
            end
            pop_exp(e);
            checks++;
            if (oResult !== e.res || oDest !== e.dest) begin
                errors++;
                $display("FAIL t2_result[%0d]: got %h/%b want %h/%b", i, oResult, oDest, e.res, e.dest);
            end
            iAck = 1'b1;
            tick();
            iAck = 1'b0;
            mdl_ptr = (w + 1) % NREQ;
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ*SIZE-1:0] a, b;
        int   w;
        bit   ok;
        exp_t e;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        mdl_ptr = 0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        iAck = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(4'b1111, a, b, w);
            wait_grant(ok);
            checks++;
            if (!ok || oGrant !== 4'(1 << w)) begin
                errors++;
                $display("FAIL t3_grant[%0d]: got %b want %b", i, oGrant, 4'(1 << w));
            end
            wait_valid(ok);
            pop_exp(e);
            checks++;
            if (!ok || oResult !== e.res || oDest !== e.dest) begin
                errors++;
                $display("FAIL t3_result[%0d]: got %h/%b want %h/%b", i, oResult, oDest, e.res, e.dest);
            end
            mdl_ptr = (w + 1) % NREQ;
        end
        iReq = '0;
        tick();
        tick();
        iAck = 1'b0;
    endtask

    task automatic test_hold();
        logic [NREQ*SIZE-1:0] a, b;
        int   w;
        bit   ok;
        exp_t e;
        a = {16'hA0A0, 16'h1357, 16'h8001, 16'h0F0F};
        b = {16'h0B0B, 16'h2468, 16'h7FFF, 16'hF0F0};
        drive_req(4'b1111, a, b, w);
        wait_grant(ok);
        checks++;
        if (!ok || oGrant !== 4'(1 << w)) begin
            errors++;
            $display("FAIL t4_grant: got %b want %b", oGrant, 4'(1 << w));
        end
        wait_valid(ok);
        pop_exp(e);
        checks++;
        if (!ok || oResult !== e.res || oDest !== e.dest) begin
            errors++;
            $display("FAIL t4_result: got %h/%b want %h/%b", oResult, oDest, e.res, e.dest);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (oValid !== 1'b1 || oResult !== e.res || oDest !== e.dest || oGrant !== 4'b0000) begin
                errors++;
                $display("FAIL t4_hold[%0d]: got v=%b r=%h d=%b g=%b want 1/%h/%b/0000",
                         i, oValid, oResult, oDest, oGrant, e.res, e.dest);
            end
        end
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        mdl_ptr = (w + 1) % NREQ;
        drive_req(4'b1111, a, b, w);
        tick();
        checks++;
        if (oGrant !== 4'b0100) begin
            errors++;
            $display("FAIL t4_next_grant: got %b want 0100", oGrant);
        end
        iReq = '0;
        wait_valid(ok);
        pop_exp(e);
        checks++;
        if (!ok || oResult !== e.res || oDest !== e.dest) begin
            errors++;
            $display("FAIL t4_next_result: got %h/%b want %h/%b", oResult, oDest, e.res, e.dest);
        end
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        mdl_ptr = (w + 1) % NREQ;
    endtask

    task automatic test_reset_in_wait();
        int   w;
        bit   ok;
        exp_t e;
        iReq = 4'b0100;
        iOpA = {16'h0, 16'h00AA, 32'h0};
        iOpB = {16'h0, 16'h00BB, 32'h0};
        tick();
        iReq = '0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (oValid !== 1'b0 || oBusy !== 1'b0 || oGrant !== 4'b0000 || oResult !== 32'h0) begin
            errors++;
            $display("FAIL t5_reset: got v=%b b=%b g=%b r=%h want 0/0/0000/0", oValid, oBusy, oGrant, oResult);
        end
        mdl_ptr = 0;
        sb.delete();
        drive_req(4'b1001, {16'h0033, 32'h0, 16'h0011}, {16'h0044, 32'h0, 16'h0022}, w);
        tick();
        checks++;
        if (oGrant !== 4'b0001) begin
            errors++;
            $display("FAIL t5_grant: got %b want 0001", oGrant);
        end
        iReq = '0;
        wait_valid(ok);
        pop_exp(e);
        checks++;
        if (!ok || oResult !== e.res || oDest !== e.dest) begin
            errors++;
            $display("FAIL t5_result: got %h/%b want %h/%b", oResult, oDest, e.res, e.dest);
        end
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        mdl_ptr = (w + 1) % NREQ;
    endtask

    task automatic test_ignore();
        int   w;
        exp_t e;
        iAck = 1'b1;
        tick();
        tick();
        iAck = 1'b0;
        checks++;
        if (oValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL t6_idle_ack: got v=%b b=%b want 0/0", oValid, oBusy);
        end
        drive_req(4'b0010, {32'h0, 16'h1234, 16'h0}, {32'h0, 16'h5678, 16'h0}, w);
        tick();
        checks++;
        if (oGrant !== 4'b0010) begin
            errors++;
            $display("FAIL t6_grant: got %b want 0010", oGrant);
        end
        iReq = '0;
        iOpA = '1;
        iOpB = '1;
        iAck = 1'b1;
        tick();
        checks++;
        if (oValid !== 1'b0 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL t6_wait_ack: got v=%b b=%b want 0/1", oValid, oBusy);
        end
        tick();
        iAck = 1'b0;
        pop_exp(e);
        checks++;
        if (oValid !== 1'b1 || oResult !== e.res || oResult !== 32'h06260060 || oDest !== e.dest) begin
            errors++;
            $display("FAIL t6_result: got v=%b r=%h d=%b want 1/%h/%b", oValid, oResult, oDest, e.res, e.dest);
        end
        tick();
        checks++;
        if (oValid !== 1'b1 || oResult !== e.res) begin
            errors++;
            $display("FAIL t6_rise_ack: got v=%b r=%h want 1/%h", oValid, oResult, e.res);
        end
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL t6_final_ack: got v=%b want 0", oValid);
        end
        mdl_ptr = (w + 1) % NREQ;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        mdl_ptr = 0;
        Reset   = 1'b1;
        iReq    = '0;
        iOpA    = '0;
        iOpB    = '0;
        iAck    = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_hold();
        test_reset_in_wait();
        test_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
